usi_uart_rx: RTL and testbench
==============================

// Module: usi_uart_rx
// PURPOSE
//  Bench-side UART receiver: the far end of the USI0 UART link. Decodes the serial stream
//  driven by the SoC on the USI0 TXD pad (sd0) into bytes using 16x oversampling, buffers
//  them in a small FIFO and hands them out on a valid/ready port. Flags glitches, framing,
//  parity and overrun errors so directed tests can check the SoC transmitter bit-exactly.
// PARAMETERS
//  DATA_BITS   8  data bits per frame (5..8), sent LSB first
//  PARITY_EN   0  1 = one parity bit follows the data bits
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
//  FIFO_DEPTH  4  receive FIFO entries, power of two >= 2
// PORTS
//  clk         in   1          single clock
//  rst_b       in   1          asynchronous, active-low reset
//  en          in   1          receiver enable; 0 aborts any frame in progress
//  baud_div    in   16         clk cycles per oversample tick (bit = 16 ticks); 0 treated as 1
//  rxd         in   1          serial input (SoC txd), idle high, asynchronous to clk
//  rx_valid    out  1          FIFO not empty
//  rx_data     out  DATA_BITS  FIFO head byte
//  rx_ready    in   1          consumer pops head when rx_valid && rx_ready
//  frame_err   out  1          1-cycle pulse: stop bit sampled low
//  par_err     out  1          1-cycle pulse: parity mismatch
//  overrun     out  1          1-cycle pulse: good byte dropped, FIFO full
//  busy        out  1          FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0, sync flops 1 (idle line).
//  - rxd through 2-FF synchronizer; all decisions use synchronized value.
//  - Tick gen: counter loads baud_div-1, decrements each clk, tick on 0 and reload;
//    new baud_div takes effect at next reload. Counter held in reload while en=0.
//  - os_cnt 0..15 counts ticks within a bit, cleared on every state change.
//  - FSM: IDLE -> START on sync rxd 1->0 with en=1.
//    START: at os_cnt 7 rxd=1 -> IDLE (glitch, no flag); rxd=0 -> DATA, os_cnt cleared
//      (all later samples fall mid-bit).
//    DATA: sample on os_cnt 15, shift right into data reg; after DATA_BITS samples ->
//      PARITY if PARITY_EN else STOP.
//    PARITY: sample at os_cnt 15; compare XOR(data,bit) vs PARITY_ODD -> STOP.
//    STOP: sample at os_cnt 15. rxd=1: good frame -> push (unless parity bad) -> IDLE.
//      rxd=0: frame_err pulse, no push -> BRK; BRK waits for sync rxd=1 -> IDLE.
//  - Parity bad: par_err pulse at stop sample, byte not pushed (also frame_err if stop=0).
//  - Push occurs the clk of the stop sample tick; rx_valid rises the following clk.
//  - FIFO: pointers wrap modulo FIFO_DEPTH with extra wrap bit for full/empty.
//    Push when full and no pop same cycle -> byte dropped, overrun pulse.
//    Push and pop same cycle when full -> both accepted, no overrun.
//    Push and pop same cycle when empty: push only (rx_valid was 0).
//    rx_data stable while rx_valid && !rx_ready.
//  - en=0: FSM -> IDLE next clk, partial byte discarded, no error flags; FIFO contents
//    and pop port unaffected.
//  - rst_b asserted mid-frame: immediate clear per reset list; after release, a line
//    still low is ignored until a fresh 1->0 edge.
// STRUCTURE
//  - Shared pkg usi_uart_pkg: FSM state encoding (IDLE, START, DATA, PARITY, STOP, BRK),
//    OS_RATE=16, OS_MID=7, OS_LAST=15 constants, reused by the matching TX model.
//  - One sub-module: usi_uart_rx_fifo (sync FIFO, DATA_BITS x FIFO_DEPTH, valid/ready pop).
//  - Top: synchronizer, tick gen, FSM, shift reg, parity, error pulses.
// TESTING
//  1 baud_div=2, rxd frame 0xA5 8N1, rx_ready=1 -> rx_valid one clk, rx_data=0xA5, no flags.
//  2 baud_div=2, rxd low 8 clk (4 ticks) then high -> no push, no flags, busy back to 0.
//  3 frame 0x3C with stop bit 0, then line high -> frame_err single pulse, FIFO empty,
//    next frame 0x11 received correctly.
//  4 rx_ready=0, send 0x01..0x05 -> overrun pulse on 5th; then pop yields 0x01..0x04 in order.
//  5 PARITY_EN=1 even: 0x07 with parity bit 1 -> accepted; 0x07 with parity 0 -> par_err, no push.
//  6 rst_b low mid-DATA of 0xFF then release with rxd high, send 0x5A -> only 0x5A delivered;
//    same with en=0 mid-frame -> no byte, no flags.

Source files
------------

// File: rtl/usi_uart_pkg.sv
// Shared UART constants and receiver state encoding.
// Also used by the matching bench-side TX model.
package usi_uart_pkg;

  localparam int OS_RATE = 16;
  localparam logic [3:0] OS_MID = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK
  } rx_state_e;

  // a divider of 0 behaves like 1
  function automatic logic [15:0] div_reload(
    input logic [15:0] div
  );
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/usi_uart_rx_if.sv
// Receive-byte handshake: master offers valid/data,
// slave answers with ready.
interface usi_uart_rx_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );

endinterface

// File: rtl/usi_uart_rx_fifo.sv
// Small synchronous receive FIFO with valid/ready pop
// and a one-cycle overrun pulse when a push is dropped.
module usi_uart_rx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  output logic          valid,
  output logic [DW-1:0] rdata,
  input  logic          ready,
  output logic          overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wp;
  logic [AW:0]   rp;
  logic          empty;
  logic          full;
  logic          pop;
  logic          wr;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && ready;
  // a pop frees the slot the push lands in
  assign wr    = push && (!full || pop);
  assign valid = !empty;
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wp      <= '0;
      rp      <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      overrun <= push && !wr;
      if (wr) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + (AW+1)'(1);
      end
      if (pop) begin
        rp <= rp + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/usi_uart_rx.sv
// 16x oversampling UART receiver for the USI0 TXD pad,
// with error pulses and a small receive FIFO.
module usi_uart_rx
  import usi_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           en,
  input  logic [15:0]    baud_div,
  input  logic           rxd,
  usi_uart_rx_if.master  rx,
  output logic           frame_err,
  output logic           par_err,
  output logic           overrun,
  output logic           busy
);

  localparam int OSW = $clog2(OS_RATE);
  localparam logic [3:0] LAST_BIT =
    4'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic                 rxd_d;
  logic [1:0]           warm;
  logic                 armed;
  logic                 fall;
  logic [15:0]          div_cnt;
  logic                 tick;
  rx_state_e            state;
  logic [OSW-1:0]       os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bad;
  logic                 sample_last;
  logic                 push;

  assign rxd_s = sync_q[1];
  // a line already low out of reset must not start a frame
  assign fall  = armed && rxd_d && !rxd_s;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sync_q <= 2'b11;
      rxd_d  <= 1'b1;
      warm   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rxd};
      rxd_d  <= rxd_s;
      warm   <= {warm[0], 1'b1};
      if (warm[1] && rxd_s) begin
        armed <= 1'b1;
      end
    end
  end

  assign tick = en && (div_cnt == 16'd0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      div_cnt <= 16'd0;
    end else if (!en || div_cnt == 16'd0) begin
      div_cnt <= div_reload(baud_div);
    end else begin
      div_cnt <= div_cnt - 16'd1;
    end
  end

  assign sample_last = tick && (os_cnt == OS_LAST);
  assign push = (state == ST_STOP) && sample_last &&
                rxd_s && !par_bad;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bad   <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      if (tick) begin
        os_cnt <= os_cnt + OSW'(1);
      end
      if (!en) begin
        state  <= ST_IDLE;
        os_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            os_cnt <= '0;
            if (fall) begin
              state   <= ST_START;
              bit_cnt <= '0;
              par_bad <= 1'b0;
            end
          end
          ST_START: begin
            if (tick && os_cnt == OS_MID) begin
              os_cnt <= '0;
              state  <= rxd_s ? ST_IDLE : ST_DATA;
            end
          end
          ST_DATA: begin
            if (sample_last) begin
              os_cnt <= '0;
              shreg  <= {rxd_s,
                         shreg[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= (PARITY_EN != 0) ?
                           ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (sample_last) begin
              os_cnt  <= '0;
              par_bad <= ((^shreg) ^ rxd_s) !=
                         (PARITY_ODD != 0);
              state   <= ST_STOP;
            end
          end
          ST_STOP: begin
            if (sample_last) begin
              os_cnt  <= '0;
              par_err <= par_bad;
              if (rxd_s) begin
                state <= ST_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BRK;
              end
            end
          end
          ST_BRK: begin
            if (rxd_s) begin
              os_cnt <= '0;
              state  <= ST_IDLE;
            end
          end
          default: begin
            os_cnt <= '0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  usi_uart_rx_fifo #(
    .DW    (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .push    (push),
    .wdata   (shreg),
    .valid   (rx.rx_valid),
    .rdata   (rx.rx_data),
    .ready   (rx.rx_ready),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_usi_uart_rx.sv
// Bench for usi_uart_rx: 8N1 and 8E1 instances fed from
// a frame-level model with queued expected bytes.
module tb_usi_uart_rx;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        en = 1'b0;
  logic        rxd = 1'b1;
  logic        rxd_p = 1'b1;
  logic        rx_ready = 1'b1;
  logic [15:0] baud_div = 16'd2;
  logic        fe0, pe0, ov0, busy0;
  logic        fe1, pe1, ov1, busy1;
  bit          rnd_ready = 1'b0;

  usi_uart_rx_if #(.DATA_BITS(8)) rif0();
  usi_uart_rx_if #(.DATA_BITS(8)) rif1();
  assign rif0.rx_ready = rx_ready;
  assign rif1.rx_ready = rx_ready;

  usi_uart_rx #(
    .DATA_BITS(8), .PARITY_EN(0),
    .PARITY_ODD(0), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .rst_b(rst_b), .en(en),
    .baud_div(baud_div), .rxd(rxd),
    .rx(rif0.master), .frame_err(fe0),
    .par_err(pe0), .overrun(ov0), .busy(busy0)
  );

  usi_uart_rx #(
    .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .FIFO_DEPTH(4)
  ) u_dutp (
    .clk(clk), .rst_b(rst_b), .en(en),
    .baud_div(baud_div), .rxd(rxd_p),
    .rx(rif1.master), .frame_err(fe1),
    .par_err(pe1), .overrun(ov1), .busy(busy1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] log0[$];
  int exp_fe[2], exp_pe[2], exp_ov[2];
  int got_fe[2], got_pe[2], got_ov[2];
  int vld_cycles = 0;
  bit busy_seen = 1'b0;
  bit hold0 = 1'b0, hold1 = 1'b0;
  logic [7:0] hd0, hd1, e;

  // compare process: pops against model queues, hold rule
  always @(negedge clk) begin
    if (!rst_b) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (rif0.rx_valid) vld_cycles++;
      if (busy0) busy_seen = 1'b1;
      if (fe0) got_fe[0]++;
      if (pe0) got_pe[0]++;
      if (ov0) got_ov[0]++;
      if (fe1) got_fe[1]++;
      if (pe1) got_pe[1]++;
      if (ov1) got_ov[1]++;
      if (hold0) begin
        checks++;
        if (!rif0.rx_valid || rif0.rx_data !== hd0) begin
          failures++;
          $display("FAIL hold0 got=%h/%b exp=%h/1",
                   rif0.rx_data, rif0.rx_valid, hd0);
        end
      end
      if (hold1) begin
        checks++;
        if (!rif1.rx_valid || rif1.rx_data !== hd1) begin
          failures++;
          $display("FAIL hold1 got=%h/%b exp=%h/1",
                   rif1.rx_data, rif1.rx_valid, hd1);
        end
      end
      if (rif0.rx_valid && rx_ready) begin
        checks++;
        log0.push_back(rif0.rx_data);
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL pop0 got=%h exp=none",
                   rif0.rx_data);
        end else begin
          e = q0.pop_front();
          if (rif0.rx_data !== e) begin
            failures++;
            $display("FAIL pop0 got=%h exp=%h",
                     rif0.rx_data, e);
          end
        end
      end
      if (rif1.rx_valid && rx_ready) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL pop1 got=%h exp=none",
                   rif1.rx_data);
        end else begin
          e = q1.pop_front();
          if (rif1.rx_data !== e) begin
            failures++;
            $display("FAIL pop1 got=%h exp=%h",
                     rif1.rx_data, e);
          end
        end
      end
      hold0 = rif0.rx_valid && !rx_ready;
      hd0 = rif0.rx_data;
      hold1 = rif1.rx_valid && !rx_ready;
      hd1 = rif1.rx_data;
    end
  end

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d",
               name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rnd_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic int bitclks();
    return 16 * ((baud_div == 16'd0) ? 1 : int'(baud_div));
  endfunction

  task automatic drive(input int d, input logic b);
    if (d == 0) rxd = b;
    else rxd_p = b;
    clks(bitclks());
  endtask

  // one frame; d=1 targets the even-parity instance
  task automatic send(input int d, input logic [7:0] b,
                      input bit stop_ok, input bit par_ok);
    bit good;
    drive(d, 1'b0);
    for (int i = 0; i < 8; i++) drive(d, b[i]);
    if (d == 1) drive(d, (^b) ^ !par_ok);
    good = stop_ok && (d == 0 || par_ok);
    if (!stop_ok) exp_fe[d]++;
    if (d == 1 && !par_ok) exp_pe[d]++;
    if (good && d == 0) begin
      if (q0.size() >= 4) exp_ov[0]++;
      else q0.push_back(b);
    end
    if (good && d == 1) begin
      if (q1.size() >= 4) exp_ov[1]++;
      else q1.push_back(b);
    end
    drive(d, stop_ok);
    if (d == 0) rxd = 1'b1;
    else rxd_p = 1'b1;
    clks(2 * bitclks());
  endtask

  task automatic settle(input string t);
    rnd_ready = 1'b0;
    rx_ready = 1'b1;
    clks(20);
    chk({t, " fe0"}, got_fe[0], exp_fe[0]);
    chk({t, " pe0"}, got_pe[0], exp_pe[0]);
    chk({t, " ov0"}, got_ov[0], exp_ov[0]);
    chk({t, " fe1"}, got_fe[1], exp_fe[1]);
    chk({t, " pe1"}, got_pe[1], exp_pe[1]);
    chk({t, " ov1"}, got_ov[1], exp_ov[1]);
    chk({t, " q0"}, q0.size(), 0);
    chk({t, " q1"}, q1.size(), 0);
    chk({t, " busy0"}, int'(busy0), 0);
    chk({t, " busy1"}, int'(busy1), 0);
  endtask

  function automatic int lg(input int i);
    return (log0.size() > i) ? int'(log0[i]) : -1;
  endfunction

  initial begin
    clks(3);
    chk("rst valid", int'(rif0.rx_valid), 0);
    chk("rst data", int'(rif0.rx_data), 0);
    chk("rst flags", int'({fe0, pe0, ov0}), 0);
    chk("rst busy", int'(busy0 | busy1), 0);
    rst_b = 1'b1;
    en = 1'b1;
    clks(10);

    // 1: single 8N1 byte, popped the cycle it appears
    log0.delete();
    vld_cycles = 0;
    send(0, 8'hA5, 1'b1, 1'b1);
    settle("t1");
    chk("t1 byte", lg(0), 'hA5);
    chk("t1 vld", vld_cycles, 1);

    // 2: short glitch is not a start bit
    busy_seen = 1'b0;
    rxd = 1'b0;
    clks(8);
    rxd = 1'b1;
    clks(60);
    chk("t2 busy seen", int'(busy_seen), 1);
    settle("t2");

    // 3: bad stop bit, then a good frame
    log0.delete();
    send(0, 8'h3C, 1'b0, 1'b1);
    send(0, 8'h11, 1'b1, 1'b1);
    settle("t3");
    chk("t3 fe", got_fe[0], 1);
    chk("t3 n", log0.size(), 1);
    chk("t3 byte", lg(0), 'h11);

    // 4: FIFO fills, fifth byte overruns
    log0.delete();
    rx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b1, 1'b1);
    chk("t4 ov", got_ov[0], 1);
    chk("t4 head", int'(rif0.rx_data), 1);
    settle("t4");
    chk("t4 n", log0.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4 order", lg(i), i + 1);

    // 5: even parity accept / reject
    send(1, 8'h07, 1'b1, 1'b1);
    send(1, 8'h07, 1'b1, 1'b0);
    settle("t5");
    chk("t5 pe", got_pe[1], 1);

    // 6a: reset in the middle of a 0xFF frame
    log0.delete();
    drive(0, 1'b0);
    for (int i = 0; i < 3; i++) drive(0, 1'b1);
    rst_b = 1'b0;
    clks(3);
    rxd = 1'b1;
    rst_b = 1'b1;
    clks(40);
    send(0, 8'h5A, 1'b1, 1'b1);
    settle("t6a");
    chk("t6a byte", lg(0), 'h5A);

    // 6b: enable dropped mid-frame
    log0.delete();
    drive(0, 1'b0);
    drive(0, 1'b1);
    drive(0, 1'b0);
    en = 1'b0;
    clks(5);
    rxd = 1'b1;
    clks(5);
    en = 1'b1;
    clks(40);
    chk("t6b n", log0.size(), 0);
    send(0, 8'h5A, 1'b1, 1'b1);
    settle("t6b");
    chk("t6b byte", lg(0), 'h5A);

    // 6c: line held low across reset release
    rst_b = 1'b0;
    rxd = 1'b0;
    clks(3);
    rst_b = 1'b1;
    busy_seen = 1'b0;
    clks(3 * bitclks());
    chk("t6c busy", int'(busy_seen), 0);
    rxd = 1'b1;
    clks(bitclks());
    settle("t6c");

    // random frames, dividers and consumer stalls
    rnd_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      baud_div = 16'($urandom_range(0, 3));
      send($urandom_range(0, 1), 8'($urandom),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0);
    end
    settle("rnd");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
